mp_add_sequencer: RTL and testbench
===================================

# mp_add_sequencer

Multi-precision add/subtract controller that sequences one 16-bit carry-lookahead adder core over the limbs of a wide operand. It processes one 16-bit limb per clock, least significant first, and chains the carry through a register. It sits in the ALU between the execute-stage operand latches and the result bus. Wide ADD/SUB operations share a single 16-bit adder instead of a full-width adder.

## Interface
- `WORDS`, default 4: number of 16-bit limbs; operand width N = 16*WORDS; legal range 2..8.
- `clk`  in  1: clock, all state updates on rising edge.
- `rst`  in  1: reset; one clock, reset is synchronous and active-high.
- `start`  in  1: request; sampled only when `busy`=0.
- `op_sub`  in  1: 0 = A+B, 1 = A−B (computed as A + ~B + 1).
- `a`  in  N: operand A; latched on accept.
- `b`  in  N: operand B; latched on accept.
- `result`  out  N: sum/difference, registered.
- `cout`  out  1: final carry out; for subtract, 1 = no borrow.
- `overflow`  out  1: signed (two's complement) overflow of the N-bit result.
- `zero`  out  1: result == 0.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle pulse, result/flags valid.

## Operation
- FSM states:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1. Limb index `idx` runs 0..WORDS−1.
  - DONE: `busy`=0, `done`=1, exactly one cycle.
- IDLE or DONE with `start`=1 → accept:
  - latch A, latch B (inverted if `op_sub`), latch `op_sub`;
  - carry register := `op_sub`; `idx` := 0;
  - clear `result`, `cout`, `overflow`; zero-accumulator := 1;
  - → RUN.
- DONE with `start`=0 → IDLE. `start` in RUN is ignored; it is neither queued nor an error.
- Each RUN cycle:
  - adder core computes A[idx] + Beff[idx] + carry;
  - the sum is written into result limb idx;
  - the carry register takes the limb carry out;
  - the zero-accumulator is ANDed with (limb sum == 0).
- Last limb (idx = WORDS−1):
  - `cout` := limb carry out;
  - `overflow` := (A msb == Beff msb) && (sum msb != A msb);
  - `zero` := final accumulator;
  - → DONE.
- `result`, `cout`, `overflow` and `zero` hold their values until the next accept.
- The latched operands are used throughout. Changes on `a`/`b` after accept have no effect.
- All arithmetic is modulo 2^N. No saturation.

## Timing
- Reset values: state IDLE, `result`=0, `cout`=0, `overflow`=0, `zero`=0, `busy`=0, `done`=0, `idx`=0, carry=0.
- Accept at edge T (`start`=1, `busy`=0):
  - `busy`=1 from T+1 through T+WORDS;
  - limb k is registered at edge T+1+k;
  - `done`=1 and flags valid in cycle T+WORDS+1 (latency WORDS+1 cycles).
- Back-to-back: a `start` seen in the DONE cycle is accepted. `busy` rises in the next cycle, so the issue interval is WORDS+1 cycles.
- `rst` has priority over all other inputs on the same edge. Reset mid-operation → IDLE next cycle with reset values, and no `done` pulse.
- `start` and `rst` asserted together → reset wins; the request is dropped.
- Final carry and zero state are only observable when `done`=1. Between accept and `done`, `result` shows a partially filled value (upper limbs 0).

## Structure
- Package `alu_pkg`:
  - `LIMB_W` = 16;
  - FSM state enum {IDLE, RUN, DONE};
  - `op_sub` encoding constants.
- Sub-module `cla16_core`: purely combinational 16-bit adder (a, b, cin → sum, cout), built from four 4-bit CLA groups.
  - It has no clock or reset; all registering is in the sequencer.
  - This keeps the controller on its synchronous active-high reset.
- `idx` counter width = clog2(WORDS).

## Test plan
All scenarios use WORDS=4 (N=64).
- **Add with full carry ripple.** A=0xFFFF_FFFF_FFFF_FFFF, B=1, add → `done` at T+5; `result`=0, `cout`=1, `zero`=1, `overflow`=0; `busy` high for exactly 4 cycles.
- **Subtract with borrow.** A=5, B=7, sub → `result`=0xFFFF_FFFF_FFFF_FFFE, `cout`=0, `overflow`=0, `zero`=0.
- **Signed overflow.**
  - A=0x7FFF_FFFF_FFFF_FFFF, B=1, add → `result`=0x8000_0000_0000_0000, `overflow`=1, `cout`=0.
  - A=0x8000_0000_0000_0000, B=1, sub → `result`=0x7FFF_FFFF_FFFF_FFFF, `overflow`=1.
- **Handshake.**
  - `start` pulsed at T+2 during RUN with different operands → ignored; the first result is unaffected; `done` fires once.
  - `start` in the DONE cycle → accepted; the second `done` comes exactly 5 cycles later.
- **Reset mid-operation.** Accept at T, `rst`=1 at edge T+2 → from T+3 `busy`=0, `result`=0, all flags 0; no `done` within the next 10 cycles.
- **Input independence after accept.** Change `a`/`b` every cycle after accept (A=0x1234_5678_9ABC_DEF0 + B=0x0F0F_0F0F_0F0F_0F0F) → `result`=0x2143_6587_A9CB_EDFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types: limb width, sequencer state encoding and op_sub encodings.
package alu_pkg;

  localparam int LIMB_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla16_core.sv
// Combinational 16-bit adder: four 4-bit carry-lookahead groups joined by a
// second-level lookahead unit over the group generate/propagate signals.
module cla16_core (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  // Returns {c4, c3, c2, c1, c0}: the carry into each of four positions plus carry out.
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic c0);
    logic [4:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | ((&p[2:0]) & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | ((&p) & c0);
    return c;
  endfunction

  logic [15:0] g, p, c_bit;
  logic [3:0]  grp_g, grp_p;
  logic [4:0]  grp_c, tmp;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    grp_g = '0;
    grp_p = '0;
    c_bit = '0;
    tmp   = '0;
    for (int i = 0; i < 4; i++) begin
      tmp      = cla4(g[4*i +: 4], p[4*i +: 4], 1'b0);
      grp_g[i] = tmp[4];
      grp_p[i] = &p[4*i +: 4];
    end
    grp_c = cla4(grp_g, grp_p, cin);
    for (int i = 0; i < 4; i++) begin
      tmp              = cla4(g[4*i +: 4], p[4*i +: 4], grp_c[i]);
      c_bit[4*i +: 4]  = tmp[3:0];
    end
    sum  = p ^ c_bit;
    cout = grp_c[4];
  end

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract: one limb per clock through a shared cla16_core,
// least significant limb first, carry chained through a register.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// RUN   | processing limb idx, busy=1
// DONE  | one-cycle done pulse, a new start is accepted here
module mp_add_sequencer
  import alu_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      op_sub,
  input  logic [LIMB_W*WORDS-1:0]   a,
  input  logic [LIMB_W*WORDS-1:0]   b,
  output logic [LIMB_W*WORDS-1:0]   result,
  output logic                      cout,
  output logic                      overflow,
  output logic                      zero,
  output logic                      busy,
  output logic                      done
);

  localparam int N     = LIMB_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  state_t           state;
  logic [N-1:0]     a_q, b_q;
  logic             carry, zacc;
  logic [IDX_W-1:0] idx;

  logic [LIMB_W-1:0] a_limb, b_limb, s_limb;
  logic              c_limb, s_zero;

  assign a_limb = a_q[idx*LIMB_W +: LIMB_W];
  assign b_limb = b_q[idx*LIMB_W +: LIMB_W];
  assign s_zero = (s_limb == '0);

  cla16_core u_core (
    .a    (a_limb),
    .b    (b_limb),
    .cin  (carry),
    .sum  (s_limb),
    .cout (c_limb)
  );

  // op_sub lives on only through the inverted b_q and the initial carry-in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry    <= 1'b0;
      zacc     <= 1'b0;
      idx      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q      <= a;
            b_q      <= (op_sub == OP_SUB) ? ~b : b;
            carry    <= op_sub;
            idx      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zacc     <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          result[idx*LIMB_W +: LIMB_W] <= s_limb;
          carry <= c_limb;
          zacc  <= zacc & s_zero;
          if (idx == LAST) begin
            cout     <= c_limb;
            overflow <= (a_limb[LIMB_W-1] == b_limb[LIMB_W-1]) &&
                        (s_limb[LIMB_W-1] != a_limb[LIMB_W-1]);
            zero     <= zacc & s_zero;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Scoreboard bench for mp_add_sequencer (WORDS=4): stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_mp_add_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, op_sub;
  logic [63:0] a, b, result;
  logic        cout, overflow, zero, busy, done;

  always #5 clk = ~clk;

  mp_add_sequencer #(.WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .result(result), .cout(cout), .overflow(overflow), .zero(zero),
    .busy(busy), .done(done)
  );

  typedef struct {
    string       name;
    logic [63:0] r;
    logic        c, v, z;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at %0t, want no pulse", $time);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"},   result,   e.r);
        check({e.name, "_cout"},     64'(cout),     64'(e.c));
        check({e.name, "_overflow"}, 64'(overflow), 64'(e.v));
        check({e.name, "_zero"},     64'(zero),     64'(e.z));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that raised done.
  // mode 0: plain, 1: scramble a/b every cycle, 2: scramble plus a start pulse mid-run.
  task automatic run_op(input string name, input logic [63:0] av, input logic [63:0] bv,
                        input logic sub, input logic [63:0] er, input logic ec,
                        input logic ev, input logic ez, input int mode);
    exp_t x;
    int   edges, n_busy;
    x.name = name; x.r = er; x.c = ec; x.v = ev; x.z = ez;
    sb.push_back(x);
    a = av; b = bv; op_sub = sub; start = 1'b1;
    tick(1);
    start  = 1'b0;
    edges  = 0;
    n_busy = 0;
    while (done !== 1'b1 && edges < 20) begin
      if (busy === 1'b1) n_busy++;
      if (mode != 0) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        op_sub = ~op_sub;
      end
      if (mode == 2) start = (edges == 1);
      tick(1);
      edges++;
    end
    start = 1'b0;
    check({name, "_latency"},     64'(edges),  64'd4);
    check({name, "_busy_cycles"}, 64'(n_busy), 64'd4);
    check({name, "_busy_in_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; op_sub = OP_ADD; a = '0; b = '0;
    tick(3);
    check("rst_result",   result,        64'd0);
    check("rst_flags",    64'({cout, overflow, zero}), 64'd0);
    check("rst_busy_done", 64'({busy, done}), 64'd0);
    rst = 1'b0;
    tick(2);

    run_op("ripple_add", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD,
           64'd0, 1'b1, 1'b0, 1'b1, 0);
    tick(3);
    run_op("sub_borrow", 64'd5, 64'd7, OP_SUB,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 0);
    tick(2);
    run_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 0);
    tick(2);
    run_op("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, OP_SUB,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 0);
    tick(2);
    run_op("indep", 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, OP_ADD,
           64'h2143_6587_A9CB_EDFF, 1'b0, 1'b0, 1'b0, 1);
    tick(2);

    d0 = n_done;
    run_op("mid_start", 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, OP_ADD,
           64'h0000_0001_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 2);
    tick(10);
    check("mid_start_done_count", 64'(n_done - d0), 64'd1);

    // back-to-back: second start issued in the DONE cycle of the first
    run_op("b2b_first", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, OP_SUB,
           64'd0, 1'b1, 1'b0, 1'b1, 0);
    run_op("b2b_second", 64'h0000_0000_0001_0000, 64'd1, OP_SUB,
           64'h0000_0000_0000_FFFF, 1'b1, 1'b0, 1'b0, 0);
    tick(3);

    // reset two edges after accept
    d0 = n_done;
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; op_sub = OP_ADD; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_busy",   64'(busy),   64'd0);
    check("midrst_result", result,      64'd0);
    check("midrst_flags",  64'({cout, overflow, zero, done}), 64'd0);
    tick(10);
    check("midrst_no_done", 64'(n_done - d0), 64'd0);

    // start together with rst is dropped
    start = 1'b1; rst = 1'b1;
    tick(1);
    start = 1'b0; rst = 1'b0;
    tick(1);
    check("rst_start_busy", 64'(busy), 64'd0);
    tick(6);
    check("rst_start_no_done", 64'(n_done - d0), 64'd0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, want test completion", $time);
    $fatal(1, "timeout");
  end

endmodule
